hd_bitops_pipe: RTL and testbench
=================================

# hd_bitops_pipe

Parametrised, pipelined bit-manipulation unit: two WIDTH-bit unsigned operands and a 3-bit opcode enter over a valid/ready handshake, and one result plus a flag leaves over a second valid/ready handshake. The block generalises the fixed 8-bit two-operand benchmark circuits in the same suite to arbitrary width and eight selectable operations. It adds a two-stage registered pipeline with full backpressure, so it can be mapped and evaluated as a sequential netlist.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept the request this cycle.
- in_op  input  3  opcode (see Operation).
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- out_y  output  WIDTH  result.
- out_flag  output  1  per-op flag.

## Operation
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0 ADD: y = a+b; flag = carry out.
  - 1 CLR_LSB: y = a&(a-1); flag = (a==0).
  - 2 TZ_MASK: y = a^(a-1); flag = (a==0).
  - 3 ISO_LSB: y = a&(-a); flag = (a==0).
  - 4 SET_LZ: y = a|(a+1); flag = (a==all-ones).
  - 5 AVG: y = (a&b)+((a^b)>>1), i.e. floor((a+b)/2) with no overflow; flag = (a^b)[0], meaning a rounding loss.
  - 6 MAXU: y = max(a,b); flag = (a>=b).
  - 7 ABSDIFF: y = |a-b|; flag = (a<b).
- Operand B is ignored for ops 1-4.
- Boundaries:
  - a=0: CLR_LSB→0, TZ_MASK→all-ones, ISO_LSB→0.
  - a=all-ones: SET_LZ→all-ones.
  - a==b: ABSDIFF→0 with flag 0; MAXU flag 1.
- Stage 1 (S1) registers op, a, b and valid.
- Stage 2 (S2) registers the ALU result, flag and valid. S2 drives out_*.
- Advance rules:
  - s2_adv = s1_v & (~s2_v | out_ready).
  - in_ready = ~s1_v | s2_adv.
  - A request is accepted when in_valid & in_ready.
- Simultaneous accept and consume is legal in both stages. There is no bubble at steady state, so throughput is 1 result/cycle.
- out_y and out_flag stay stable while out_valid & ~out_ready. Results are delivered in acceptance order; none are dropped or duplicated.
- Data registers load only on advance. Held values are not cleared when valid drops.

## Timing
- Latency: a request accepted at edge N appears with out_valid=1 after edge N+1, when unstalled.
- in_ready depends combinationally on out_ready, through one AND/OR level.
- No combinational path from in_* to out_*.
- Reset, asynchronous, any cycle including mid-stream:
  - s1_v=0, s2_v=0, out_valid=0, out_y=0, out_flag=0.
  - in_ready=1 while rst_n is low and after release.
  - In-flight items are discarded.
- First acceptance is possible on the first rising edge after rst_n deasserts.
- Inputs are don't-care while in_valid=0. out_ready is don't-care while out_valid=0.

## Structure
- Package hd_bitops_pkg:
  - op_e enum (OP_ADD..OP_ABSDIFF, 3 bits).
  - localparam OP_W=3.
- Sub-module hd_bitops_alu: purely combinational; WIDTH param; (op, a, b) → (y, flag). It is instantiated once between S1 and S2 and is also synthesisable standalone for combinational benchmarks.
- Top holds only the two register stages and the handshake logic.

## Test plan
- ADD, WIDTH=8, a=0xF0, b=0x20, out_ready=1 → out_y=0x10, flag=1, out_valid exactly 2 edges after accept.
- TZ_MASK a=0x58 → 0x0F, flag 0; a=0x00 → 0xFF, flag 1; CLR_LSB 0x58 → 0x50; ISO_LSB 0x58 → 0x08; SET_LZ 0x57 → 0x5F.
- AVG 0xFF,0xFD → 0xFE, flag 0; AVG 0x03,0x00 → 0x01, flag 1; ABSDIFF 0x10,0x30 → 0x20, flag 1; MAXU 0x7F,0x80 → 0x80, flag 0.
- Backpressure:
  - Stimulus: 6 back-to-back requests with out_ready low for cycles 2-5.
  - Required: in_ready drops once both stages are full, out_y is held stable, all 6 results emerge in order, and throughput returns to 1/cycle.
- Reset mid-stream: assert rst_n=0 with both stages valid → out_valid=0 immediately (async), no stale result after release, next request result is correct.
- WIDTH=16 and WIDTH=2, random ops and operands, 10k transactions, random out_ready → scoreboard match against a reference model.

Source files
------------

// File: rtl/hd_bitops_pkg.sv
// Shared opcode encoding and widths for the hd_bitops pipelined bit-manipulation unit.
package hd_bitops_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD     = 3'd0,
        OP_CLR_LSB = 3'd1,
        OP_TZ_MASK = 3'd2,
        OP_ISO_LSB = 3'd3,
        OP_SET_LZ  = 3'd4,
        OP_AVG     = 3'd5,
        OP_MAXU    = 3'd6,
        OP_ABSDIFF = 3'd7
    } op_e;

endpackage

// File: rtl/hd_bitops_alu.sv
// Purely combinational bit-manipulation ALU: (op, a, b) -> (y, flag), all arithmetic modulo 2^WIDTH.
// Usable standalone as a combinational benchmark netlist.
module hd_bitops_alu
    import hd_bitops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             flag
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] a_dec;
    logic [WIDTH-1:0] a_inc;
    logic [WIDTH-1:0] a_neg;
    logic             a_zero;
    logic             a_ones;
    logic             a_ge_b;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign a_dec  = a - ONE;
    assign a_inc  = a + ONE;
    assign a_neg  = ~a + ONE;
    assign a_zero = (a == '0);
    assign a_ones = (a == '1);
    assign a_ge_b = (a >= b);

    always_comb begin
        y    = '0;
        flag = 1'b0;
        case (op)
            OP_ADD: begin
                y    = sum[WIDTH-1:0];
                flag = sum[WIDTH];
            end
            OP_CLR_LSB: begin
                y    = a & a_dec;
                flag = a_zero;
            end
            OP_TZ_MASK: begin
                y    = a ^ a_dec;
                flag = a_zero;
            end
            OP_ISO_LSB: begin
                y    = a & a_neg;
                flag = a_zero;
            end
            OP_SET_LZ: begin
                y    = a | a_inc;
                flag = a_ones;
            end
            OP_AVG: begin
                // Overflow-free floor((a+b)/2); flag marks the dropped half.
                y    = (a & b) + ((a ^ b) >> 1);
                flag = a[0] ^ b[0];
            end
            OP_MAXU: begin
                y    = a_ge_b ? a : b;
                flag = a_ge_b;
            end
            OP_ABSDIFF: begin
                y    = a_ge_b ? (a - b) : (b - a);
                flag = ~a_ge_b;
            end
            default: begin
                y    = '0;
                flag = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hd_bitops_pipe.sv
// Two-stage registered wrapper around hd_bitops_alu with full valid/ready backpressure.
// S1 holds the accepted request; S2 holds the ALU result and drives out_*.
module hd_bitops_pipe
    import hd_bitops_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_flag
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and the payload is held stable while valid & ~ready.
    logic             s1_v;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_v;
    logic [WIDTH-1:0] s2_y;
    logic             s2_flag;

    logic             s2_adv;
    logic             in_fire;
    logic [WIDTH-1:0] alu_y;
    logic             alu_flag;

    assign s2_adv   = s1_v & (~s2_v | out_ready);
    assign in_ready = ~s1_v | s2_adv;
    assign in_fire  = in_valid & in_ready;

    hd_bitops_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op   (s1_op),
        .a    (s1_a),
        .b    (s1_b),
        .y    (alu_y),
        .flag (alu_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_op <= OP_ADD;
            s1_a  <= '0;
            s1_b  <= '0;
        end else begin
            if (in_fire) begin
                s1_v  <= 1'b1;
                s1_op <= op_e'(in_op);
                s1_a  <= in_a;
                s1_b  <= in_b;
            end else if (s2_adv) begin
                s1_v  <= 1'b0;
            end
        end
    end

    // Data registers only load on advance; a drained stage keeps its last payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_y    <= '0;
            s2_flag <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_v    <= 1'b1;
                s2_y    <= alu_y;
                s2_flag <= alu_flag;
            end else if (out_ready) begin
                s2_v    <= 1'b0;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_y     = s2_y;
    assign out_flag  = s2_flag;

endmodule

// File: tb/tb_hd_bitops_pipe.sv
// Self-checking bench for hd_bitops_pipe: directed ops at WIDTH=8, backpressure, mid-stream
// reset, and randomized scoreboard runs at WIDTH=16 and WIDTH=2.
module tb_hd_bitops_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- WIDTH=8 instance ----------------
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_y;
    logic       out_flag;

    hd_bitops_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flag(out_flag)
    );

    // ---------------- WIDTH=16 and WIDTH=2 instances (index 0 and 1) ----------------
    logic [1:0]  r_in_valid = 2'b00;
    logic [1:0]  r_out_ready = 2'b11;
    logic [2:0]  rop[2];
    logic [63:0] ra[2];
    logic [63:0] rb[2];

    logic        r16_in_ready, r16_out_valid, r16_out_flag;
    logic [15:0] r16_out_y;
    logic        r2_in_ready, r2_out_valid, r2_out_flag;
    logic [1:0]  r2_out_y;

    hd_bitops_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_in_valid[0]), .in_ready(r16_in_ready), .in_op(rop[0]),
        .in_a(ra[0][15:0]), .in_b(rb[0][15:0]),
        .out_valid(r16_out_valid), .out_ready(r_out_ready[0]), .out_y(r16_out_y),
        .out_flag(r16_out_flag)
    );

    hd_bitops_pipe #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(r_in_valid[1]), .in_ready(r2_in_ready), .in_op(rop[1]),
        .in_a(ra[1][1:0]), .in_b(rb[1][1:0]),
        .out_valid(r2_out_valid), .out_ready(r_out_ready[1]), .out_y(r2_out_y),
        .out_flag(r2_out_flag)
    );

    // ---------------- reference model (from the operation definitions) ----------------
    function automatic void ref_op(input int w, input logic [2:0] op, input logic [63:0] a,
                                   input logic [63:0] b, output logic [63:0] y, output logic f);
        logic [63:0] mask;
        int lsb;
        int lz;
        mask = (64'd1 << w) - 64'd1;
        lsb = w;
        lz = w;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i]) lsb = i;
            if (!a[i]) lz = i;
        end
        y = 64'd0;
        f = 1'b0;
        case (op)
            3'd0: begin y = (a + b) & mask; f = ((a + b) > mask); end
            3'd1: begin y = (a == 0) ? 64'd0 : (a & ~(64'd1 << lsb)); f = (a == 0); end
            3'd2: begin y = (a == 0) ? mask : ((64'd1 << (lsb + 1)) - 64'd1); f = (a == 0); end
            3'd3: begin y = (a == 0) ? 64'd0 : (64'd1 << lsb); f = (a == 0); end
            3'd4: begin y = (a == mask) ? mask : (a | (64'd1 << lz)); f = (a == mask); end
            3'd5: begin y = (a + b) / 2; f = ((a + b) % 2) != 0; end
            3'd6: begin y = (a >= b) ? a : b; f = (a >= b); end
            default: begin y = (a >= b) ? (a - b) : (b - a); f = (a < b); end
        endcase
    endfunction

    logic [8:0]  exp_q8[$];
    logic [64:0] exp_q16[$];
    logic [64:0] exp_q2[$];

    // ---------------- driver tasks / tests ----------------
    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_y !== 8'h00 || out_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b out_y=%h out_flag=%b, want 0 1 00 0",
                     out_valid, in_ready, out_y, out_flag);
        end
        checks++;
        if (r16_out_valid !== 1'b0 || r2_out_valid !== 1'b0 || r16_in_ready !== 1'b1 || r2_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state_wide: ov16=%b ov2=%b ir16=%b ir2=%b, want 0 0 1 1",
                     r16_out_valid, r2_out_valid, r16_in_ready, r2_in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] ey, input logic ef);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency_early: out_valid=%b want 0 one edge after accept", name, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_y !== ey || out_flag !== ef) begin
            errors++;
            $display("FAIL %s: out_valid=%b y=%h flag=%b, want 1 y=%h flag=%b",
                     name, out_valid, out_y, out_flag, ey, ef);
        end
    endtask

    task automatic test_ops();
        check_op("add",        3'd0, 8'hF0, 8'h20, 8'h10, 1'b1);
        check_op("tz_mask",    3'd2, 8'h58, 8'h33, 8'h0F, 1'b0);
        check_op("tz_mask_0",  3'd2, 8'h00, 8'h77, 8'hFF, 1'b1);
        check_op("clr_lsb",    3'd1, 8'h58, 8'hAA, 8'h50, 1'b0);
        check_op("clr_lsb_0",  3'd1, 8'h00, 8'h11, 8'h00, 1'b1);
        check_op("iso_lsb",    3'd3, 8'h58, 8'h00, 8'h08, 1'b0);
        check_op("iso_lsb_0",  3'd3, 8'h00, 8'hFF, 8'h00, 1'b1);
        check_op("set_lz",     3'd4, 8'h57, 8'h00, 8'h5F, 1'b0);
        check_op("set_lz_1s",  3'd4, 8'hFF, 8'h00, 8'hFF, 1'b1);
        check_op("avg",        3'd5, 8'hFF, 8'hFD, 8'hFE, 1'b0);
        check_op("avg_round",  3'd5, 8'h03, 8'h00, 8'h01, 1'b1);
        check_op("absdiff",    3'd7, 8'h10, 8'h30, 8'h20, 1'b1);
        check_op("absdiff_eq", 3'd7, 8'h42, 8'h42, 8'h00, 1'b0);
        check_op("maxu",       3'd6, 8'h7F, 8'h80, 8'h80, 1'b0);
        check_op("maxu_eq",    3'd6, 8'h42, 8'h42, 8'h42, 1'b1);
        idle8(2);
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops[6];
        logic [7:0] as[6];
        logic [7:0] bs[6];
        int exp_rdy[13] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        int exp_ov[13]  = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int idx = 0;
        int got = 0;
        logic stalled = 1'b0;
        logic [7:0] held_y = 8'h00;
        logic held_f = 1'b0;
        logic [63:0] ey;
        logic ef;
        logic [8:0] e;
        for (int i = 0; i < 6; i++) begin
            ops[i] = 3'($urandom_range(0, 7));
            as[i] = 8'($urandom);
            bs[i] = 8'($urandom);
        end
        exp_q8.delete();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            in_valid = (idx < 6);
            if (idx < 6) begin
                in_op = ops[idx]; in_a = as[idx]; in_b = bs[idx];
            end
            out_ready = !(c >= 2 && c <= 5);
            #1;
            checks++;
            if (in_ready !== exp_rdy[c][0]) begin
                errors++;
                $display("FAIL bp_in_ready c%0d: got %b want %0d", c, in_ready, exp_rdy[c]);
            end
            checks++;
            if (out_valid !== exp_ov[c][0]) begin
                errors++;
                $display("FAIL bp_out_valid c%0d: got %b want %0d", c, out_valid, exp_ov[c]);
            end
            if (stalled) begin
                checks++;
                if (out_y !== held_y || out_flag !== held_f) begin
                    errors++;
                    $display("FAIL bp_hold c%0d: y=%h flag=%b want y=%h flag=%b",
                             c, out_y, out_flag, held_y, held_f);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q8.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra_result c%0d: y=%h with nothing expected", c, out_y);
                end else begin
                    e = exp_q8.pop_front();
                    got++;
                    if ({out_flag, out_y} !== e) begin
                        errors++;
                        $display("FAIL bp_result c%0d: flag=%b y=%h want flag=%b y=%h",
                                 c, out_flag, out_y, e[8], e[7:0]);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                ref_op(8, in_op, {56'd0, in_a}, {56'd0, in_b}, ey, ef);
                exp_q8.push_back({ef, ey[7:0]});
                idx++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held_y = out_y;
            held_f = out_flag;
        end
        checks++;
        if (got != 6 || idx != 6) begin
            errors++;
            $display("FAIL bp_count: accepted=%0d delivered=%0d want 6 6", idx, got);
        end
        idle8(1);
    endtask

    task automatic test_reset_midstream();
        idle8(1);
        @(negedge clk);
        in_valid = 1'b1; in_op = 3'd0; in_a = 8'h11; in_b = 8'h22; out_ready = 1'b0;
        @(negedge clk);
        in_a = 8'h33; in_b = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_y !== 8'h00 || out_flag !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: out_valid=%b y=%h flag=%b in_ready=%b want 0 00 0 1",
                     out_valid, out_y, out_flag, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_stale cycle%0d: out_valid=%b y=%h want 0", i, out_valid, out_y);
            end
        end
        check_op("after_reset", 3'd7, 8'h05, 8'h09, 8'h04, 1'b1);
        idle8(2);
    endtask

    task automatic test_random(input int n_txn);
        int sent[2];
        int got[2];
        int cyc = 0;
        int w;
        logic stalled[2];
        logic [63:0] held_y[2];
        logic held_f[2];
        logic [63:0] mask;
        logic rdy, ov, of;
        logic [63:0] oy;
        logic [63:0] ey;
        logic ef;
        logic [64:0] e;
        logic empty;
        for (int k = 0; k < 2; k++) begin
            sent[k] = 0; got[k] = 0; stalled[k] = 1'b0; held_y[k] = 64'd0; held_f[k] = 1'b0;
        end
        exp_q16.delete();
        exp_q2.delete();
        while ((got[0] < n_txn || got[1] < n_txn) && cyc < 60000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? 16 : 2;
                mask = (64'd1 << w) - 64'd1;
                r_in_valid[k] = (sent[k] < n_txn) && ($urandom_range(0, 3) != 0);
                rop[k] = 3'($urandom_range(0, 7));
                ra[k] = {$urandom, $urandom} & mask;
                rb[k] = {$urandom, $urandom} & mask;
                if ($urandom_range(0, 7) == 0) ra[k] = mask;
                r_out_ready[k] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                w = (k == 0) ? 16 : 2;
                rdy = (k == 0) ? r16_in_ready : r2_in_ready;
                ov = (k == 0) ? r16_out_valid : r2_out_valid;
                of = (k == 0) ? r16_out_flag : r2_out_flag;
                oy = (k == 0) ? {48'd0, r16_out_y} : {62'd0, r2_out_y};
                if (stalled[k]) begin
                    checks++;
                    if (ov !== 1'b1 || oy !== held_y[k] || of !== held_f[k]) begin
                        errors++;
                        $display("FAIL rand_w%0d_hold: ov=%b y=%h flag=%b want 1 y=%h flag=%b",
                                 w, ov, oy, of, held_y[k], held_f[k]);
                    end
                end
                if (ov === 1'b1 && r_out_ready[k]) begin
                    checks++;
                    empty = (k == 0) ? (exp_q16.size() == 0) : (exp_q2.size() == 0);
                    if (empty) begin
                        errors++;
                        $display("FAIL rand_w%0d_extra: y=%h with nothing expected", w, oy);
                    end else begin
                        e = (k == 0) ? exp_q16.pop_front() : exp_q2.pop_front();
                        got[k]++;
                        if ({of, oy} !== e) begin
                            errors++;
                            $display("FAIL rand_w%0d_result #%0d: flag=%b y=%h want flag=%b y=%h",
                                     w, got[k], of, oy, e[64], e[63:0]);
                        end
                    end
                end
                if (r_in_valid[k] && rdy === 1'b1) begin
                    ref_op(w, rop[k], ra[k], rb[k], ey, ef);
                    if (k == 0) exp_q16.push_back({ef, ey});
                    else exp_q2.push_back({ef, ey});
                    sent[k]++;
                end
                stalled[k] = (ov === 1'b1) && !r_out_ready[k];
                held_y[k] = oy;
                held_f[k] = of;
            end
            cyc++;
        end
        @(negedge clk);
        r_in_valid = 2'b00;
        r_out_ready = 2'b11;
        checks++;
        if (got[0] != n_txn || got[1] != n_txn || exp_q16.size() != 0 || exp_q2.size() != 0) begin
            errors++;
            $display("FAIL rand_complete: w16 got %0d w2 got %0d want %0d each, leftovers %0d %0d, cycles %0d",
                     got[0], got[1], n_txn, exp_q16.size(), exp_q2.size(), cyc);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            rop[k] = 3'd0; ra[k] = 64'd0; rb[k] = 64'd0;
        end
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_midstream();
        test_random(10000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
